// File: rtl/stereo_matrix_gain_seq_if.sv
// Sample-pair in / scaled L+R, L-R out bundle for the stereo matrix gain stage.
// Handshake: in_valid/in_ready on the input side, single-cycle out_valid on the result side.
// The slave holds in_ready low while a pair is in flight; results cannot be back-pressured.
interface stereo_matrix_gain_seq_if #(
    parameter int DW = 18,
    parameter int KW = 4
);
    logic signed [DW-1:0] LEFT;
    logic signed [DW-1:0] RIGHT;
    logic        [KW-1:0] Ks;
    logic        [KW-1:0] Kd;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] LpR_out;
    logic signed [DW-1:0] LmR_out;
    logic                 out_valid;
    logic                 sat_s;
    logic                 sat_d;

    modport master (
        output LEFT, RIGHT, Ks, Kd, in_valid,
        input  in_ready, LpR_out, LmR_out, out_valid, sat_s, sat_d
    );

    modport slave (
        input  LEFT, RIGHT, Ks, Kd, in_valid,
        output in_ready, LpR_out, LmR_out, out_valid, sat_s, sat_d
    );
endinterface

// File: rtl/stereo_matrix_gain_seq.sv
// Stereo L+R / L-R matrix with per-path gain on one time-shared shift-add multiplier.
// Latency: out_valid 2*KW+1 edges after acceptance; one pair per 2*KW+2 cycles.
// Backpressure: in_ready low from acceptance until the result is issued; outputs hold between results.
module stereo_matrix_gain_seq #(
    parameter int DW    = 18,
    parameter int KW    = 4,
    parameter int FRAC  = 3,
    parameter int ROUND = 1
) (
    input  logic               clock,
    input  logic               reset,
    stereo_matrix_gain_seq_if.slave bus
);
    localparam int PW = DW + KW;
    localparam int CW = (KW > 1) ? $clog2(KW) : 1;
    localparam logic signed [PW:0] RND =
        (ROUND != 0) ? (((PW+1)'(1) << FRAC) >> 1) : '0;

    typedef enum logic [1:0] {IDLE, MUL_S, MUL_D, DONE} state_t;

    state_t               state;
    logic signed [PW-1:0] acc;
    logic signed [PW-1:0] mcand;
    logic signed [PW-1:0] prod_s;
    logic        [KW-1:0] gain;
    logic        [KW-1:0] kd_r;
    logic signed [DW-1:0] op_d;
    logic                 pre_s;
    logic                 pre_d;
    logic        [CW-1:0] cnt;
    logic                 in_ready_r;
    logic                 out_valid_r;
    logic signed [DW-1:0] lpr_r;
    logic signed [DW-1:0] lmr_r;
    logic                 sat_s_r;
    logic                 sat_d_r;

    logic signed [DW:0]   sum_w;
    logic signed [DW:0]   diff_w;
    logic signed [DW-1:0] sum_sat;
    logic signed [DW-1:0] diff_sat;
    logic                 sum_ov;
    logic                 diff_ov;
    logic signed [PW-1:0] acc_next;
    logic        [DW:0]   fin_s;
    logic        [DW:0]   fin_d;
    logic                 last_bit;

    // Rounded arithmetic shift then clamp; MSB of the result is the overflow flag.
    function automatic logic [DW:0] scale(input logic signed [PW-1:0] p);
        logic signed [PW:0] r;
        logic               ov;
        r  = ($signed({p[PW-1], p}) + RND) >>> FRAC;
        ov = !((&r[PW:DW-1]) || !(|r[PW:DW-1]));
        scale = ov ? {1'b1, r[PW], {(DW-1){~r[PW]}}} : {1'b0, r[DW-1:0]};
    endfunction

    always_comb begin
        sum_w    = {bus.LEFT[DW-1], bus.LEFT} + {bus.RIGHT[DW-1], bus.RIGHT};
        diff_w   = {bus.LEFT[DW-1], bus.LEFT} - {bus.RIGHT[DW-1], bus.RIGHT};
        sum_ov   = sum_w[DW] ^ sum_w[DW-1];
        diff_ov  = diff_w[DW] ^ diff_w[DW-1];
        sum_sat  = sum_ov  ? {sum_w[DW],  {(DW-1){~sum_w[DW]}}}  : sum_w[DW-1:0];
        diff_sat = diff_ov ? {diff_w[DW], {(DW-1){~diff_w[DW]}}} : diff_w[DW-1:0];
        acc_next = gain[0] ? acc + mcand : acc;
        last_bit = (cnt == CW'(KW-1));
        fin_s    = scale(prod_s);
        fin_d    = scale(acc);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            acc         <= '0;
            mcand       <= '0;
            prod_s      <= '0;
            gain        <= '0;
            kd_r        <= '0;
            op_d        <= '0;
            pre_s       <= 1'b0;
            pre_d       <= 1'b0;
            cnt         <= '0;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            lpr_r       <= '0;
            lmr_r       <= '0;
            sat_s_r     <= 1'b0;
            sat_d_r     <= 1'b0;
        end else begin
            out_valid_r <= 1'b0;
            case (state)
                IDLE: begin
                    in_ready_r <= 1'b1;
                    if (bus.in_valid && in_ready_r) begin
                        in_ready_r <= 1'b0;
                        mcand      <= {{KW{sum_sat[DW-1]}}, sum_sat};
                        op_d       <= diff_sat;
                        gain       <= bus.Ks;
                        kd_r       <= bus.Kd;
                        pre_s      <= sum_ov;
                        pre_d      <= diff_ov;
                        acc        <= '0;
                        cnt        <= '0;
                        state      <= MUL_S;
                    end
                end
                MUL_S: begin
                    if (last_bit) begin
                        prod_s <= acc_next;
                        acc    <= '0;
                        mcand  <= {{KW{op_d[DW-1]}}, op_d};
                        gain   <= kd_r;
                        cnt    <= '0;
                        state  <= MUL_D;
                    end else begin
                        acc   <= acc_next;
                        mcand <= mcand <<< 1;
                        gain  <= gain >> 1;
                        cnt   <= cnt + 1'b1;
                    end
                end
                MUL_D: begin
                    acc <= acc_next;
                    if (last_bit) begin
                        state <= DONE;
                    end else begin
                        mcand <= mcand <<< 1;
                        gain  <= gain >> 1;
                        cnt   <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    lpr_r       <= fin_s[DW-1:0];
                    lmr_r       <= fin_d[DW-1:0];
                    sat_s_r     <= pre_s | fin_s[DW];
                    sat_d_r     <= pre_d | fin_d[DW];
                    out_valid_r <= 1'b1;
                    in_ready_r  <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.LpR_out   = lpr_r;
    assign bus.LmR_out   = lmr_r;
    assign bus.sat_s     = sat_s_r;
    assign bus.sat_d     = sat_d_r;
endmodule
